// File: rtl/uart_rx_fifo_if.sv
// Byte stream between the receive FIFO and the host logic.
// The FIFO drives data/valid as master; the consumer answers with ready.
interface uart_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: turns the UART receiver's frame-valid level into
// one capture per frame and queues bytes in a first-word-fall-through FIFO.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic                   rx_break,
    input  logic [7:0]             rx_data,
    uart_rx_fifo_if.master         stream,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   overflow,
    input  logic                   overflow_clr,
    output logic                   break_seen
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          valid_d;
    logic          cap;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [CW-1:0] count_next;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        cap        = valid_d & ~rx_valid;
        full       = (count == CW'(DEPTH));
        pop        = (count != '0) & stream.m_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push       = cap & ~rx_break & (~full | pop);
        drop       = cap & ~rx_break & full & ~pop;
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_d     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            break_seen  <= 1'b0;
        end else begin
            valid_d     <= rx_valid;
            count       <= count_next;
            almost_full <= (count_next >= CW'(ALMOST_FULL));
            break_seen  <= cap & rx_break;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; stale entries are never visible because m_data is gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    assign stream.m_valid = (count != '0);
    assign stream.m_data  = (count != '0) ? mem[rd_ptr] : 8'h00;
endmodule
